// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble controller for the five-stage pipeline.
// Two miss sequencers (D = data side, I = fetch side) plus the combinational
// hold/zero decode for PC, if_id, id_ex, ex_mem and mem_wb.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no miss outstanding; a request here is the first stall cycle
// WAIT  | miss outstanding, counter running down toward the fill
// FILL  | miss data valid this cycle (one cycle), back to IDLE next
module hazard_ctrl #(
    parameter int MISS_LATENCY = 5,
    parameter int CNT_W        = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmiss_req,
    input  logic        imiss_req,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        exception_at_mem,
    output logic        stall_at_fetch,
    output logic        stall_at_decode,
    output logic        stall_at_exec,
    output logic        stall_at_memory,
    output logic        bubble_at_decode,
    output logic        bubble_at_exec,
    output logic        bubble_at_memory,
    output logic        bubble_at_wb,
    output logic        dfill,
    output logic        ifill,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FILL = 2'd2
    } miss_state_t;

    // Counter load value; a latency of 1 loads 0 and skips WAIT entirely.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MISS_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    miss_state_t      d_state, i_state;
    logic [CNT_W-1:0] d_cnt, i_cnt;

    logic active;
    logic sd, si, fl, lu;

    // Outputs are forced low while reset is held so they drop asynchronously
    // even if a miss request is still asserted by its source.
    assign active = !reset;

    assign sd = active & (((d_state == ST_IDLE) & dmiss_req) | (d_state == ST_WAIT));
    assign si = active & (((i_state == ST_IDLE) & imiss_req) | (i_state == ST_WAIT));
    assign fl = active & (branch_taken | exception_at_mem) & !sd;
    assign lu = active & load_use & !fl & !sd;

    assign stall_at_memory  = sd;
    assign stall_at_exec    = sd;
    assign stall_at_decode  = sd | lu;
    assign stall_at_fetch   = sd | si | lu;
    assign bubble_at_wb     = sd | (active & exception_at_mem & !sd);
    assign bubble_at_memory = fl;
    assign bubble_at_exec   = fl | lu;
    assign bubble_at_decode = fl | (si & !sd & !lu);
    assign dfill            = active & (d_state == ST_FILL);
    assign ifill            = active & (i_state == ST_FILL) & !fl;

    // D-side miss sequencer; never aborted by a flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_state <= ST_IDLE;
            d_cnt   <= '0;
        end else begin
            case (d_state)
                ST_IDLE: begin
                    if (dmiss_req) begin
                        d_cnt   <= LOAD_VAL;
                        d_state <= (LOAD_VAL == '0) ? ST_FILL : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    d_cnt <= d_cnt - CNT_ONE;
                    if (d_cnt == CNT_ONE) d_state <= ST_FILL;
                end
                ST_FILL: d_state <= ST_IDLE;
                default: d_state <= ST_IDLE;
            endcase
        end
    end

    // I-side miss sequencer; a flush discards the outstanding fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_state <= ST_IDLE;
            i_cnt   <= '0;
        end else if (fl) begin
            i_state <= ST_IDLE;
            i_cnt   <= '0;
        end else begin
            case (i_state)
                ST_IDLE: begin
                    if (imiss_req) begin
                        i_cnt   <= LOAD_VAL;
                        i_state <= (LOAD_VAL == '0) ? ST_FILL : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    i_cnt <= i_cnt - CNT_ONE;
                    if (i_cnt == CNT_ONE) i_state <= ST_FILL;
                end
                ST_FILL: i_state <= ST_IDLE;
                default: i_state <= ST_IDLE;
            endcase
        end
    end

    // Performance counter of fetch-stall cycles; wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_cycles <= '0;
        else if (stall_at_fetch) stall_cycles <= stall_cycles + 32'd1;
    end

endmodule
